// File: rtl/csum_pkg.sv
// Shared definitions for the streaming ones-complement checksum controller.
package csum_pkg;

    localparam int unsigned CSUM_W        = 16;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned MAX_WORDS_DEF = 375;  // 1500-byte packet of 32-bit words

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } csum_state_e;

endpackage

// File: rtl/csum_add3_fold.sv
// Combinational 3-term ones-complement add: acc + hi + lo with double end-around fold.
// The result never carries a pending carry; 16'hFFFF is returned as-is.
module csum_add3_fold
    import csum_pkg::*;
(
    input  logic [CSUM_W-1:0] acc_i,
    input  logic [CSUM_W-1:0] hi_i,
    input  logic [CSUM_W-1:0] lo_i,
    output logic [CSUM_W-1:0] sum_o
);

    logic [CSUM_W+1:0] s;
    logic [CSUM_W:0]   f1;

    // Three 16-bit terms fit in 18 bits; two folds absorb every carry.
    always_comb begin
        s     = {2'b00, acc_i} + {2'b00, hi_i} + {2'b00, lo_i};
        f1    = {1'b0, s[CSUM_W-1:0]} + {{(CSUM_W-1){1'b0}}, s[CSUM_W+1:CSUM_W]};
        sum_o = f1[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, f1[CSUM_W]};
    end

endmodule

// File: rtl/csum_stream_ctrl.sv
// Streaming Internet checksum sequencer: folds 32-bit words into a ones-complement
// accumulator and presents ~sum on a valid/ready result port.
// Optional: define CSUM_STREAM_VERIFY_EN to add out_ok (final sum == 16'hFFFF).
module csum_stream_ctrl
    import csum_pkg::*;
#(
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CSUM_W-1:0] out_checksum,
    output logic              out_err,
`ifdef CSUM_STREAM_VERIFY_EN
    output logic              out_ok,
`endif
    output logic [CNT_W-1:0]  word_count,
    output logic              busy
);

    csum_state_e       state_q;
    logic [CSUM_W-1:0] acc_q;
    logic [CSUM_W-1:0] acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_valid_q;
    logic [CSUM_W-1:0] out_checksum_q;
    logic              out_err_q;
`ifdef CSUM_STREAM_VERIFY_EN
    logic              out_ok_q;
`endif

    logic accept;
    logic at_limit;

    csum_add3_fold u_fold (
        .acc_i (acc_q),
        .hi_i  (in_data[31:16]),
        .lo_i  (in_data[15:0]),
        .sum_o (acc_d)
    );

    // Handshake and terminal-word decode from current state.
    always_comb begin
        in_ready = (state_q != StDone);
        busy     = (state_q != StIdle);
        accept   = in_valid && in_ready;
        at_limit = (cnt_q == CNT_W'(MAX_WORDS - 1));
    end

    // Packet FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            acc_q          <= '0;
            cnt_q          <= '0;
            out_valid_q    <= 1'b0;
            out_checksum_q <= '0;
            out_err_q      <= 1'b0;
`ifdef CSUM_STREAM_VERIFY_EN
            out_ok_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        if (cnt_q != CNT_W'(MAX_WORDS)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (in_last || at_limit) begin
                            state_q        <= StDone;
                            out_valid_q    <= 1'b1;
                            out_checksum_q <= ~acc_d;
                            // Overflow only when the limit, not in_last, ended the packet.
                            out_err_q      <= !in_last;
`ifdef CSUM_STREAM_VERIFY_EN
                            out_ok_q       <= (acc_d == 16'hFFFF);
`endif
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
`ifdef CSUM_STREAM_VERIFY_EN
                        out_ok_q    <= 1'b0;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_checksum = out_checksum_q;
    assign out_err      = out_err_q;
    assign word_count   = cnt_q;
`ifdef CSUM_STREAM_VERIFY_EN
    assign out_ok       = out_ok_q;
`endif

endmodule

// File: tb/tb_csum_stream_ctrl.sv
// Self-checking bench for csum_stream_ctrl (MAX_WORDS=4) using an expected-result queue.
module tb_csum_stream_ctrl;

    localparam int unsigned MAXW = 4;
    localparam int unsigned CW   = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_checksum;
    logic          out_err;
    logic [CW-1:0] word_count;
    logic          busy;
`ifdef CSUM_STREAM_VERIFY_EN
    logic          out_ok;
`endif

    csum_stream_ctrl #(
        .MAX_WORDS (MAXW),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_checksum (out_checksum),
        .out_err      (out_err),
`ifdef CSUM_STREAM_VERIFY_EN
        .out_ok       (out_ok),
`endif
        .word_count   (word_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] csum;
        logic        err;
        logic        ok;
        int          cnt;
    } exp_t;

    exp_t     exp_q[$];
    int       n_total = 0;
    int       n_bad   = 0;
    int       n_push  = 0;
    int       n_pop   = 0;
    bit [31:0] m_sum  = 0;
    int        m_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain 32-bit sum of all terms, folded once at packet end.
    task automatic model_accept(input logic [31:0] d, input logic last);
        exp_t e;
        bit [31:0] t;
        m_sum = m_sum + {16'h0, d[31:16]} + {16'h0, d[15:0]};
        m_cnt++;
        if (last || m_cnt == MAXW) begin
            t = m_sum;
            while (t[31:16] != 16'h0) t = {16'h0, t[15:0]} + {16'h0, t[31:16]};
            e.csum = ~t[15:0];
            e.err  = !last;
            e.ok   = (t[15:0] == 16'hFFFF);
            e.cnt  = m_cnt;
            exp_q.push_back(e);
            n_push++;
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(d, last);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        m_sum = 0;
        m_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_out_err", {31'b0, out_err}, 32'd0);
        check_eq("rst_checksum", {16'b0, out_checksum}, 32'd0);
        check_eq("rst_word_count", {16'b0, word_count}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    // Scoreboard: compare each result as the handshake is about to complete.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", {31'b0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_pop++;
                check_eq("checksum", {16'b0, out_checksum}, {16'b0, e.csum});
                check_eq("err", {31'b0, out_err}, {31'b0, e.err});
                check_eq("count", {16'b0, word_count}, e.cnt);
`ifdef CSUM_STREAM_VERIFY_EN
                check_eq("ok", {31'b0, out_ok}, {31'b0, e.ok});
`endif
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Single word: result one cycle after the accept.
        send_word(32'h9D2DC3D5, 1'b1);
        @(negedge clk);
        check_eq("lat1_valid", {31'b0, out_valid}, 32'd1);
        check_eq("lat1_checksum", {16'b0, out_checksum}, 32'h9EFC);
        check_eq("lat1_in_ready", {31'b0, in_ready}, 32'd0);

        // Two words with a 3-cycle in_valid gap.
        send_word(32'h00010002, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("gap_count", {16'b0, word_count}, 32'd1);
        check_eq("gap_valid", {31'b0, out_valid}, 32'd0);
        send_word(32'h00030004, 1'b1);
        @(negedge clk);
        check_eq("two_checksum", {16'b0, out_checksum}, 32'hFFF5);

        // End-around carry chain.
        send_word(32'hFFFFFFFF, 1'b0);
        send_word(32'h00010000, 1'b1);
        @(negedge clk);
        check_eq("carry_checksum", {16'b0, out_checksum}, 32'hFFFE);

        // Backpressure: result held stable while out_ready is low.
        @(posedge clk);
        #1 out_ready = 1'b0;
        send_word(32'h9D2DC3D5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", {31'b0, out_valid}, 32'd1);
            check_eq("bp_checksum", {16'b0, out_checksum}, 32'h9EFC);
            check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_release_ready", {31'b0, in_ready}, 32'd1);
        check_eq("bp_release_busy", {31'b0, busy}, 32'd0);
        send_word(32'h12345678, 1'b1);

        // Overflow: 4 words without in_last terminate with err; rest is a new packet.
        for (int i = 0; i < 4; i++) send_word(32'h11112222 * (i + 1), 1'b0);
        @(negedge clk);
        check_eq("ovf_valid", {31'b0, out_valid}, 32'd1);
        check_eq("ovf_err", {31'b0, out_err}, 32'd1);
        send_word(32'hAAAA5555, 1'b0);
        send_word(32'h0F0FF0F0, 1'b0);
        send_word(32'h80008000, 1'b1);
        @(negedge clk);
        check_eq("ovf_next_err", {31'b0, out_err}, 32'd0);

        // Reset mid-packet discards partial sum.
        send_word(32'hDEADBEEF, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        do_reset();
        send_word(32'h9D2DC3D5, 1'b1);
        @(negedge clk);
        check_eq("post_rst_checksum", {16'b0, out_checksum}, 32'h9EFC);

        // Packet carrying its own checksum verifies to zero.
        send_word(32'h9D2DC3D5, 1'b0);
        send_word(32'h9EFC0000, 1'b1);
        @(negedge clk);
        check_eq("verify_checksum", {16'b0, out_checksum}, 32'h0000);

        // Random short packets.
        for (int p = 0; p < 6; p++) begin
            int len;
            len = $urandom_range(1, 3);
            for (int w = 0; w < len; w++) send_word($urandom, (w == len - 1));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", exp_q.size(), 32'd0);
        check_eq("results_seen", n_pop, n_push);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/csum_stream_ctrl.md
Name: csum_stream_ctrl

Overview:
- Sequences the 16-bit ones-complement (Internet) checksum over a multi-word packet.
- Accepts a stream of 32-bit words under valid/ready handshake, one word per clock.
- Folds each word into a running ones-complement accumulator and presents the final inverted 16-bit checksum on a valid/ready output port.
- Sits between a packet-word source and the header-insertion/verification logic.

Parameters:
MAX_WORDS, 375, max words per packet (1500 bytes); the word at this count is forced to terminate the packet.
CNT_W, 16, width of word counter; must satisfy 2**CNT_W > MAX_WORDS.

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
in_valid  input  1  in_data/in_last valid
in_ready  output  1  controller can accept a word
in_data  input  32  packet word; [31:16] and [15:0] are two 16-bit checksum terms
in_last  input  1  final word of packet
out_valid  output  1  out_checksum valid
out_ready  input  1  consumer accepts result
out_checksum  output  16  ~(ones-complement sum of all 16-bit terms)
out_err  output  1  qualifies out_valid; packet hit MAX_WORDS without in_last
word_count  output  CNT_W  words accepted in current packet
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, acc=16'h0000, word_count=0, out_valid=0, out_checksum=0, out_err=0, busy=0. Reset mid-packet discards the packet; in_ready=1 on the first cycle after reset.
- Accept: a word is accepted when in_valid && in_ready.
- States:
  - IDLE: in_ready=1. Accept -> ACCUM, or -> DONE if in_last.
  - ACCUM: in_ready=1. Accept with in_last, or with word_count==MAX_WORDS-1 -> DONE. Otherwise stay.
  - DONE: in_ready=0, out_valid=1. On out_ready -> IDLE, acc=0, word_count=0, out_err=0.
- Accumulate per accepted word:
  - s = acc + in_data[31:16] + in_data[15:0], 18 bits.
  - f1 = s[15:0] + s[17:16].
  - acc_next = f1[15:0] + f1[16].
  - acc never holds a carry. 16'hFFFF is retained; no negative-zero normalisation.
- Output:
  - out_checksum = ~acc_next, registered on the terminating beat.
  - out_valid rises the cycle after the last word is accepted (latency 1). Held stable with out_checksum until out_ready.
  - No accept occurs while DONE; a new packet can start the cycle after the out_ready handshake.
- word_count increments on each accept and saturates at MAX_WORDS.
- Overflow: if the MAX_WORDS-th word is accepted without in_last, the packet terminates there and out_err=1 with out_valid. Remaining source words are treated as a new packet.
- Input rules:
  - in_valid deasserted mid-packet -> hold state, no change.
  - in_last is ignored unless in_valid.

Optional Feature:
- Macro CSUM_STREAM_VERIFY_EN.
- When defined: adds output port out_ok (1 bit, reset 0), valid with out_valid, =1 iff the final acc==16'hFFFF (checksum field included in the stream verifies correct). Cleared on the out_ready handshake.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package csum_pkg: state encoding (IDLE/ACCUM/DONE), CSUM_W=16, DATA_W=32, default MAX_WORDS.
- Sub-module csum_add3_fold: combinational 3-term ones-complement add with double end-around fold (acc, hi, lo -> acc_next). Reused by the existing single-word checksum path.

Test Plan:
- Single word 32'h9D2DC3D5 with in_last, out_ready=1 -> out_valid one cycle later, out_checksum=16'h9EFC, word_count=1, out_err=0.
- Two words 32'h00010002, 32'h00030004 (last on 2nd), in_valid gap of 3 cycles between -> out_checksum=16'hFFF5.
- Carry chain: words 32'hFFFFFFFF, 32'h00010000 (last) -> acc=16'h0001 after wrap, out_checksum=16'hFFFE.
- Backpressure: hold out_ready=0 for 5 cycles after result -> out_valid/out_checksum stable, in_ready=0; new packet accepted the cycle after out_ready.
- Overflow with MAX_WORDS=4: stream 6 words without in_last -> after 4th word out_err=1, out_valid=1; words 5-6 start the next packet.
- Reset mid-packet after 2 words, then single word 32'h9D2DC3D5 last -> out_checksum=16'h9EFC. With CSUM_STREAM_VERIFY_EN, packet 32'h9D2DC3D5, 32'h9EFC0000 -> out_checksum=16'h0000, out_ok=1.
